// File: rtl/snoop_width_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_width_packer_pkg
//  Purpose  : Constants and helper functions shared by the forwarder read-side
//             width adapter and the snooper write-side width packer.
//             No ports (package).
//  Revision : 1.0  initial release
// ============================================================================
package snoop_width_packer_pkg;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Narrow beats per wide memory word.
   function automatic int n_lanes(input int mem_width, input int sn_width);
      return mem_width / sn_width;
   endfunction

   function automatic int lane_idx_width(input int mem_width, input int sn_width);
      return clog2(n_lanes(mem_width, sn_width));
   endfunction

   function automatic int bytes_per_beat(input int sn_width);
      return sn_width / 8;
   endfunction

   // One extra bit so a completely full memory's byte count is representable.
   function automatic int plen_width(input int mem_width, input int mem_addr_width);
      return mem_addr_width + clog2(mem_width / 8) + 1;
   endfunction

   // Values for the default 64/32/9 configuration.
   localparam int DEF_MEM_WIDTH      = 64;
   localparam int DEF_SN_WIDTH       = 32;
   localparam int DEF_MEM_ADDR_WIDTH = 9;
   localparam int N_LANES            = n_lanes(DEF_MEM_WIDTH, DEF_SN_WIDTH);
   localparam int LANE_IDX_WIDTH     = lane_idx_width(DEF_MEM_WIDTH, DEF_SN_WIDTH);
   localparam int BYTES_PER_BEAT     = bytes_per_beat(DEF_SN_WIDTH);
   localparam int PLEN_WIDTH         = plen_width(DEF_MEM_WIDTH, DEF_MEM_ADDR_WIDTH);

   // Packet FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage : snoop_width_packer_pkg
`default_nettype wire

// File: rtl/snoop_width_packer_lane.sv
`default_nettype none
// ============================================================================
//  Module   : sn_lane_packer
//  Purpose  : Gathers narrow beats into a wide word, first beat in the most
//             significant lane, and presents a registered one-cycle word
//             strobe when the last lane fills or the packet ends.
//  Ports    : clk, rst (sync, active-low)
//             beat_acc  - a beat is accepted this cycle
//             beat_last - accepted beat closes the packet
//             beat_data - accepted beat payload
//             word_vld  - registered strobe: word_data holds a complete word
//             word_data - packed word, unfilled lanes zero
//  Revision : 1.0  initial release
// ============================================================================
module sn_lane_packer
   import snoop_width_packer_pkg::*;
#(
   parameter int MEM_WIDTH = 64,
   parameter int SN_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 beat_acc,
   input  logic                 beat_last,
   input  logic [SN_WIDTH-1:0]  beat_data,
   output logic                 word_vld,
   output logic [MEM_WIDTH-1:0] word_data
);

   localparam int N  = n_lanes(MEM_WIDTH, SN_WIDTH);
   localparam int LW = lane_idx_width(MEM_WIDTH, SN_WIDTH);

   logic [LW-1:0]        lane_q, lane_d;
   logic [MEM_WIDTH-1:0] acc_q, acc_d;
   logic                 word_vld_q, word_vld_d;
   logic [MEM_WIDTH-1:0] word_data_q, word_data_d;

   // Accumulator with the incoming beat dropped into the current lane.
   logic [MEM_WIDTH-1:0] merged;

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign merged[MEM_WIDTH-1-i*SN_WIDTH -: SN_WIDTH] =
         (lane_q == LW'(i)) ? beat_data : acc_q[MEM_WIDTH-1-i*SN_WIDTH -: SN_WIDTH];
   end

   always_comb begin
      lane_d      = lane_q;
      acc_d       = acc_q;
      word_vld_d  = 1'b0;
      word_data_d = word_data_q;
      if (beat_acc) begin
         if ((lane_q == LW'(N - 1)) || beat_last) begin
            // Word complete: hand it out and restart from an all-zero
            // accumulator so a short final word has zero tail lanes.
            word_vld_d  = 1'b1;
            word_data_d = merged;
            acc_d       = '0;
            lane_d      = '0;
         end else begin
            acc_d  = merged;
            lane_d = lane_q + LW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         lane_q      <= '0;
         acc_q       <= '0;
         word_vld_q  <= 1'b0;
         word_data_q <= '0;
      end else begin
         lane_q      <= lane_d;
         acc_q       <= acc_d;
         word_vld_q  <= word_vld_d;
         word_data_q <= word_data_d;
      end
   end

   assign word_vld  = word_vld_q;
   assign word_data = word_data_q;

endmodule : sn_lane_packer
`default_nettype wire

// File: rtl/snoop_width_packer.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_width_packer
//  Purpose  : Packs a narrow snooped packet stream into wide packet-memory
//             words written at sequential addresses from 0, and reports the
//             packet byte length and truncation when the packet completes.
//  Ports    : clk, rst (sync, active-low)
//             buf_rdy     - packet buffer free, a packet may start
//             sn_data/sn_vld/sn_last/sn_rdy - narrow input stream
//             mem_addr/mem_wr_data/mem_wr_en - packet memory write port
//             pkt_done    - one-cycle pulse when the packet is committed
//             pkt_len     - byte count (saturating), valid with pkt_done
//             pkt_trunc   - packet overflowed memory, valid with pkt_done
//  Revision : 1.0  initial release
// ============================================================================
module snoop_width_packer
   import snoop_width_packer_pkg::*;
#(
   parameter  int MEM_WIDTH      = 64,
   parameter  int SN_WIDTH       = 32,
   parameter  int MEM_ADDR_WIDTH = 9,
   localparam int PLEN_WIDTH     = plen_width(MEM_WIDTH, MEM_ADDR_WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      buf_rdy,
   input  logic [SN_WIDTH-1:0]       sn_data,
   input  logic                      sn_vld,
   input  logic                      sn_last,
   output logic                      sn_rdy,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [MEM_WIDTH-1:0]      mem_wr_data,
   output logic                      mem_wr_en,
   output logic                      pkt_done,
   output logic [PLEN_WIDTH-1:0]     pkt_len,
   output logic                      pkt_trunc
);

   localparam int BPB = bytes_per_beat(SN_WIDTH);

   state_e                    state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic                      full_q, full_d;
   logic [PLEN_WIDTH-1:0]     len_q, len_d;
   logic                      trunc_q, trunc_d;

   logic                      beat_acc;
   logic                      start;
   logic                      word_vld;
   logic [MEM_WIDTH-1:0]      word_data;
   logic                      wr_fire;
   logic [PLEN_WIDTH:0]       len_sum;

   assign sn_rdy   = (state_q == ST_RECV);
   assign beat_acc = sn_vld & sn_rdy;
   assign start    = (state_q == ST_IDLE) & buf_rdy;

   sn_lane_packer #(
      .MEM_WIDTH (MEM_WIDTH),
      .SN_WIDTH  (SN_WIDTH)
   ) u_lane_packer (
      .clk       (clk),
      .rst       (rst),
      .beat_acc  (beat_acc),
      .beat_last (sn_last),
      .beat_data (sn_data),
      .word_vld  (word_vld),
      .word_data (word_data)
   );

   // Once memory is full, completed words are dropped instead of written.
   assign wr_fire = word_vld & ~full_q;

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      full_d   = full_q;
      len_d    = len_q;
      trunc_d  = trunc_q;
      len_sum  = {1'b0, len_q} + (PLEN_WIDTH + 1)'(BPB);

      case (state_q)
         ST_IDLE:  if (buf_rdy) state_d = ST_RECV;
         ST_RECV:  if (beat_acc && sn_last) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (start) begin
         wr_cnt_d = '0;
         full_d   = 1'b0;
         len_d    = '0;
         trunc_d  = 1'b0;
      end else begin
         if (wr_fire) begin
            // Park on the last address rather than wrapping; the full flag
            // marks that every address has been used.
            if (wr_cnt_q == {MEM_ADDR_WIDTH{1'b1}}) begin
               full_d = 1'b1;
            end else begin
               wr_cnt_d = wr_cnt_q + MEM_ADDR_WIDTH'(1);
            end
         end
         // A word completing after memory filled means data was lost; an
         // exactly-full packet never produces such a word.
         if (word_vld && full_q) begin
            trunc_d = 1'b1;
         end
         if (beat_acc) begin
            len_d = len_sum[PLEN_WIDTH] ? {PLEN_WIDTH{1'b1}} : len_sum[PLEN_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         wr_cnt_q <= '0;
         full_q   <= 1'b0;
         len_q    <= '0;
         trunc_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         full_q   <= full_d;
         len_q    <= len_d;
         trunc_q  <= trunc_d;
      end
   end

   assign mem_addr    = wr_cnt_q;
   assign mem_wr_data = word_data;
   assign mem_wr_en   = wr_fire;
   assign pkt_done    = (state_q == ST_DONE);
   assign pkt_len     = len_q;
   assign pkt_trunc   = trunc_q;

endmodule : snoop_width_packer
`default_nettype wire
